// File: rtl/rx_lbuf_mgr_pkg.sv
// rx_lbuf_mgr_pkg -- shared constants and types for the RX large-buffer manager.
//   state_t  : one-hot FSM encoding (WAIT, ACTIVE, GRANT, CLOSE, DONE)
//   QW_SHIFT : log2 of bytes per qword; converts qword counts to byte counts
package rx_lbuf_mgr_pkg;

  localparam int QW_SHIFT = 3;

  typedef enum logic [4:0] {
    ST_WAIT   = 5'b00001,
    ST_ACTIVE = 5'b00010,
    ST_GRANT  = 5'b00100,
    ST_CLOSE  = 5'b01000,
    ST_DONE   = 5'b10000
  } state_t;

endpackage

// File: rtl/rx_lbuf_mgr.sv
// rx_lbuf_mgr -- ping-pongs between two host-armed receive buffers, carving
// qword-granular write regions for the packet writer and reporting each buffer
// back to the host when it is full or flushed.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   lbufN_addr/len/en        host buffer N descriptor (en held until lbufN_dn)
//   lbufN_dn                 one-cycle pulse: buffer N returned to host
//   wr_req, wr_qw            writer space request (held until wr_gnt), size in qwords
//   wr_gnt, wr_addr          one-cycle grant with host address of the region
//   flush                    pulse: close the current buffer early
//   cpl_req/idx/bytes        completion notice, held until cpl_ack
//   cpl_ack                  completion notice consumed
//   err                      sticky: a request did not fit an empty buffer
//   dbg_state                current FSM state for observation
//
// Handshakes: wr_req/wr_gnt is a level request answered by a single-cycle
// grant (the writer must drop or change wr_req after seeing wr_gnt);
// cpl_req/cpl_ack is valid/ready style -- cpl_req and its payload stay stable
// until cpl_ack is sampled high on a rising clock edge.
module rx_lbuf_mgr
  import rx_lbuf_mgr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] lbuf1_addr,
  input  logic [31:0] lbuf1_len,
  input  logic        lbuf1_en,
  output logic        lbuf1_dn,
  input  logic [63:0] lbuf2_addr,
  input  logic [31:0] lbuf2_len,
  input  logic        lbuf2_en,
  output logic        lbuf2_dn,
  input  logic        wr_req,
  input  logic [8:0]  wr_qw,
  output logic        wr_gnt,
  output logic [63:0] wr_addr,
  input  logic        flush,
  output logic        cpl_req,
  output logic        cpl_idx,
  output logic [31:0] cpl_bytes,
  input  logic        cpl_ack,
  output logic        err,
  output state_t      dbg_state
);

  localparam logic [31:0] QW_MASK = ~((32'd1 << QW_SHIFT) - 32'd1);

  state_t      state;
  state_t      state_nxt;
  logic        cur;
  logic [63:0] base;
  logic [31:0] size;
  logic [31:0] offset;
  logic [31:0] gnt_bytes;
  logic        flush_pend;
  logic        err_q;

  // Current-buffer mux; the other buffer's enable is ignored until cur toggles.
  logic        sel_en;
  logic [63:0] sel_addr;
  logic [31:0] sel_len;

  logic [31:0] req_bytes;
  logic [32:0] fit_sum;
  logic        fits;
  logic        flush_clr;
  logic        err_set;

  assign sel_en   = cur ? lbuf2_en   : lbuf1_en;
  assign sel_addr = cur ? lbuf2_addr : lbuf1_addr;
  assign sel_len  = cur ? lbuf2_len  : lbuf1_len;

  assign req_bytes = 32'(wr_qw) << QW_SHIFT;
  // One extra bit so an offset near 2^32 cannot wrap into a false fit.
  assign fit_sum   = {1'b0, offset} + {1'b0, req_bytes};
  assign fits      = (fit_sum <= {1'b0, size});

  assign err       = err_q;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    flush_clr = 1'b0;
    err_set   = 1'b0;
    wr_gnt    = 1'b0;
    wr_addr   = 64'd0;
    cpl_req   = 1'b0;
    cpl_idx   = 1'b0;
    cpl_bytes = 32'd0;
    lbuf1_dn  = 1'b0;
    lbuf2_dn  = 1'b0;
    case (state)
      ST_WAIT: begin
        if (sel_en) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // A fitting request always wins over a pending flush, so the flush
        // then closes a buffer that already includes that grant.
        if (wr_req && fits) begin
          state_nxt = ST_GRANT;
        end else if (wr_req) begin
          // Request stays pending and is retried against the next buffer.
          state_nxt = ST_CLOSE;
          flush_clr = 1'b1;
          if (offset == 32'd0) err_set = 1'b1;
        end else if (flush_pend) begin
          flush_clr = 1'b1;
          if (offset != 32'd0) state_nxt = ST_CLOSE;
        end
      end
      ST_GRANT: begin
        wr_gnt    = 1'b1;
        wr_addr   = base + {32'd0, offset};
        state_nxt = ST_ACTIVE;
      end
      ST_CLOSE: begin
        cpl_req   = 1'b1;
        cpl_idx   = cur;
        cpl_bytes = offset;
        if (cpl_ack) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        lbuf1_dn  = ~cur;
        lbuf2_dn  = cur;
        state_nxt = ST_WAIT;
      end
      default: state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_WAIT;
      cur        <= 1'b0;
      base       <= 64'd0;
      size       <= 32'd0;
      offset     <= 32'd0;
      gnt_bytes  <= 32'd0;
      flush_pend <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      // A new flush pulse outranks a same-cycle clear so it is never lost.
      flush_pend <= flush | (flush_pend & ~flush_clr);
      err_q      <= err_q | err_set;
      case (state)
        ST_WAIT: begin
          if (sel_en) begin
            base   <= sel_addr;
            size   <= sel_len & QW_MASK;
            offset <= 32'd0;
          end
        end
        ST_ACTIVE: begin
          // Capture the granted size so the offset update does not depend on
          // wr_qw after the writer has seen its grant.
          if (wr_req && fits) gnt_bytes <= req_bytes;
        end
        ST_GRANT: offset <= offset + gnt_bytes;
        ST_DONE:  cur    <= ~cur;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rx_lbuf_mgr.md
RX_LBUF_MGR -- requirements
Module: rx_lbuf_mgr

Interface
REQ-001 SHALL have clk, input, 1, clock; all logic on its rising edge.
REQ-002 SHALL have rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have lbuf1_addr / lbuf2_addr, input, 64, host byte address of buffer 1/2, stable while lbufN_en is high.
REQ-004 SHALL have lbuf1_len / lbuf2_len, input, 32, buffer size in bytes; bits [2:0] ignored, so size is truncated to whole qwords.
REQ-005 SHALL have lbuf1_en / lbuf2_en, input, 1, level: buffer N is armed by host, held high until lbufN_dn.
REQ-006 SHALL have lbuf1_dn / lbuf2_dn, output, 1, one-cycle pulse: buffer N closed and returned to host.
REQ-007 SHALL have wr_req, input, 1, level: the packet writer requests space; held until wr_gnt.
REQ-008 SHALL have wr_qw, input, 9, size of the request in qwords, 1..256, stable while wr_req is high.
REQ-009 SHALL have wr_gnt, output, 1, one-cycle grant pulse.
REQ-010 SHALL have wr_addr, output, 64, host address for the granted write, valid with wr_gnt.
REQ-011 SHALL have flush, input, 1, pulse: close the current buffer early.
REQ-012 SHALL have cpl_req, output, 1, level: completion notice pending, held until cpl_ack.
REQ-013 SHALL have cpl_idx, output, 1, buffer index being closed (0 = buffer 1, 1 = buffer 2).
REQ-014 SHALL have cpl_bytes, output, 32, bytes written into the closed buffer.
REQ-015 SHALL have cpl_ack, input, 1, completion notice consumed.
REQ-016 SHALL have err, output, 1, sticky error flag: a request exceeded a whole empty buffer.

Function
REQ-017 SHALL use FSM states WAIT, ACTIVE, GRANT, CLOSE and DONE, plus register cur (0 = buffer 1, 1 = buffer 2).
REQ-018 SHALL, in WAIT, on lbuf[cur]_en high, latch base and size (len[31:3]), clear offset, and enter ACTIVE next cycle.
REQ-019 SHALL, in ACTIVE with wr_req high and offset + 8*wr_qw <= size, enter GRANT.
- Next cycle: wr_gnt=1, wr_addr=base+offset, offset += 8*wr_qw.
- Then return to ACTIVE.
- Consecutive grants are therefore at least 2 cycles apart.
REQ-020 SHALL, in ACTIVE with wr_req high and the request not fitting, enter CLOSE; wr_req stays pending for the next buffer.
REQ-021 SHALL latch flush into flush_pend in any state; in ACTIVE with flush_pend high, offset > 0 and no fitting request, enter CLOSE and clear flush_pend.
REQ-022 SHALL service a fitting wr_req before flush_pend when both are present in the same cycle.
REQ-023 SHALL clear flush_pend without any close when offset = 0.
REQ-024 SHALL, when a request does not fit and offset = 0, set err (sticky until rst) and still close the buffer with cpl_bytes = 0.
REQ-025 SHALL, in CLOSE, drive cpl_req=1, cpl_idx=cur, cpl_bytes=offset, holding them until cpl_ack is sampled high; then enter DONE.
REQ-026 SHALL, in DONE, drop cpl_req, pulse lbuf[cur]_dn for exactly one cycle, toggle cur, and enter WAIT.
REQ-027 SHALL compute offset as 32-bit unsigned; the fit comparison SHALL be done at 33 bits so it never wraps.
REQ-028 SHALL ignore the enable of the non-current buffer; an early-armed buffer is consumed on the next WAIT.

Reset
REQ-029 SHALL, on rst, go to state WAIT with cur=0, offset=0 and flush_pend=0.
REQ-030 SHALL, on rst, drive wr_gnt, lbuf1_dn, lbuf2_dn, cpl_req, cpl_idx and err to 0, and wr_addr and cpl_bytes to 0.
REQ-031 SHALL, on rst mid-operation (including during CLOSE), abandon the buffer without a dn pulse or cpl_req.

Structure
REQ-032 SHALL take its one-hot state constants and the qword shift constant (3) from the shared includes package.
REQ-033 SHALL be a single FSM with no sub-module; buffer selection is an inline mux on cur.

Verification
REQ-034 Arm buf1 (addr 0x1000_0000, len 4096), then wr_req qw=64 three times -> wr_gnt with wr_addr 0x1000_0000, 0x1000_0200, 0x1000_0400, each one cycle after acceptance.
REQ-035 Buf1 len 1024, fill with 2 x qw=64, then request qw=1 -> cpl_req idx=0 bytes=1024; after cpl_ack, lbuf1_dn pulses 1 cycle; with buf2 armed (0x2000_0000), grant at 0x2000_0000.
REQ-036 Buf1 armed, qw=8 granted, then flush -> cpl_bytes=64, lbuf1_dn; a flush with offset 0 -> no cpl_req and no dn.
REQ-037 Flush and a fitting wr_req in the same cycle -> the grant is issued first, then close with bytes including that grant.
REQ-038 Buf len 16, request qw=4 -> err=1 and cpl_bytes=0.
REQ-039 Hold cpl_ack low for 10 cycles -> cpl_req held; then assert rst mid-CLOSE -> all outputs 0 with no dn.
